// File: rtl/tmon_alarm_slave_pkg.sv
// ---------------------------------------------------------------------------
// tmon_alarm_slave_pkg
// Shared definitions for the temperature alarm engine: command opcodes,
// response/alarm status codes, configuration reset values and the saturating
// arithmetic used to derive the hysteresis exit bounds.
// ---------------------------------------------------------------------------
package tmon_alarm_slave_pkg;

    typedef enum logic [2:0] {
        NOP      = 3'd0,
        SET_HI   = 3'd1,
        SET_LO   = 3'd2,
        SET_HYST = 3'd3,
        ENABLE   = 3'd4,
        DISABLE  = 3'd5,
        CLEAR    = 3'd6,
        QUERY    = 3'd7
    } tmon_op_e;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_NORMAL   = 3'd1,
        ST_HOT      = 3'd2,
        ST_COLD     = 3'd3,
        ST_ERR      = 3'd4
    } tmon_status_e;

    localparam logic [7:0] TMON_HI_RST   = 8'd200;
    localparam logic [7:0] TMON_LO_RST   = 8'd10;
    localparam logic [7:0] TMON_HYST_RST = 8'd2;

    // a - b computed 9-bit, clamped at 0
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        sat_sub = d[8] ? 8'd0 : d[7:0];
    endfunction

    // a + b computed 9-bit, clamped at 255
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[8] ? 8'd255 : s[7:0];
    endfunction

endpackage

// File: rtl/tmon_bus.sv
// ---------------------------------------------------------------------------
// tmon_bus
// Command/response link between a host sequencer (Master) and the alarm
// engine (Slave).
//   op, opnd : command and operand, Master -> Slave
//   status   : result code (or live alarm state when valid is low)
//   valid    : one-cycle response strobe
//   ready    : Slave can accept a command this cycle
// ---------------------------------------------------------------------------
interface tmon_bus #(parameter type DTYPE = logic [7:0]);
    import tmon_alarm_slave_pkg::*;

    tmon_op_e     op;
    DTYPE         opnd;
    tmon_status_e status;
    logic         valid;
    logic         ready;

    modport Master (output op, output opnd, input status, input valid, input ready);
    modport Slave  (input op, input opnd, output status, output valid, output ready);
endinterface

// File: rtl/tmon_debounce.sv
// ---------------------------------------------------------------------------
// tmon_debounce
// Counts consecutive strobed samples that are out of range on one side and
// raises trip on the sample that completes DEBOUNCE consecutive hits.
//   clk, reset : clock, synchronous active-high reset
//   hit        : current sample is out of range on this side
//   strobe     : a sample is being evaluated this cycle
//   clr        : clear the count (takes priority over strobe)
//   trip       : combinational, high on the qualifying sample
// ---------------------------------------------------------------------------
module tmon_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic strobe,
    input  logic clr,
    output logic trip
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic [3:0] cnt_r;

    // Consecutive-hit counter, saturating at DEBOUNCE; any miss restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (clr) begin
            cnt_r <= 4'd0;
        end else if (strobe) begin
            if (hit) begin
                cnt_r <= (cnt_r < DB) ? cnt_r + 4'd1 : cnt_r;
            end else begin
                cnt_r <= 4'd0;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Trip on the hit that brings the count to DEBOUNCE, so the alarm can
    // register on the same edge that captures the sample.
    assign trip = strobe & hit & (cnt_r >= (DB - 4'd1));

endmodule

// File: rtl/tmon_alarm_slave.sv
// ---------------------------------------------------------------------------
// tmon_alarm_slave
// Command-driven temperature alarm engine. Holds hi/lo thresholds and a
// hysteresis band, debounces the sensor stream into DISABLED/NORMAL/HOT/COLD
// and answers each command (IDLE -> EXEC -> RESP) with a one-cycle valid.
//   clk, reset         : clock, synchronous active-high reset
//   bus                : tmon_bus Slave (op/opnd in; status/valid/ready out)
//   temp_in, temp_vld  : sensor sample and its qualifier
//   alarm_hot/_cold    : registered, high while state is HOT / COLD
// ---------------------------------------------------------------------------
module tmon_alarm_slave
    import tmon_alarm_slave_pkg::*;
#(
    parameter type DTYPE    = logic [7:0],
    parameter int  DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    tmon_bus.Slave     bus,
    input  logic [7:0] temp_in,
    input  logic       temp_vld,
    output logic       alarm_hot,
    output logic       alarm_cold
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   fsm_r, fsm_nxt_s;
    tmon_op_e     op_r;
    DTYPE         opnd_r, hi_r, lo_r, hyst_r;
    tmon_status_e alarm_r, alarm_nxt_s, status_r;
    logic         valid_r, ready_r, alarm_hot_r, alarm_cold_r;

    logic         accept_s, enabled_s, err_s, cmd_clr_s, clr_s;
    logic         strobe_s, hot_trip_s, cold_trip_s;
    logic [7:0]   hot_exit_s, cold_exit_s;

    assign accept_s    = (fsm_r == S_IDLE) && ready_r && (bus.op != NOP);
    assign enabled_s   = (alarm_r != ST_DISABLED);
    assign strobe_s    = temp_vld && (alarm_r == ST_NORMAL);
    assign hot_exit_s  = sat_sub(hi_r, hyst_r);
    assign cold_exit_s = sat_add(lo_r, hyst_r);

    tmon_debounce #(.DEBOUNCE(DEBOUNCE)) u_hot (
        .clk(clk), .reset(reset), .hit(temp_in > hi_r),
        .strobe(strobe_s), .clr(clr_s), .trip(hot_trip_s)
    );

    tmon_debounce #(.DEBOUNCE(DEBOUNCE)) u_cold (
        .clk(clk), .reset(reset), .hit(temp_in < lo_r),
        .strobe(strobe_s), .clr(clr_s), .trip(cold_trip_s)
    );

    // Command sequencer next state
    always_comb begin
        fsm_nxt_s = S_IDLE;
        case (fsm_r)
            S_IDLE:  fsm_nxt_s = accept_s ? S_EXEC : S_IDLE;
            S_EXEC:  fsm_nxt_s = S_RESP;
            S_RESP:  fsm_nxt_s = S_IDLE;
            default: fsm_nxt_s = S_IDLE;
        endcase
    end

    // Alarm next state: sample rules first, then an executing command overrides
    always_comb begin
        alarm_nxt_s = alarm_r;
        err_s       = 1'b0;
        cmd_clr_s   = 1'b0;
        if (temp_vld) begin
            case (alarm_r)
                ST_NORMAL: begin
                    if (hot_trip_s) begin
                        alarm_nxt_s = ST_HOT;
                    end else if (cold_trip_s) begin
                        alarm_nxt_s = ST_COLD;
                    end else begin
                        alarm_nxt_s = alarm_r;
                    end
                end
                ST_HOT:  alarm_nxt_s = (temp_in < hot_exit_s)  ? ST_NORMAL : alarm_r;
                ST_COLD: alarm_nxt_s = (temp_in > cold_exit_s) ? ST_NORMAL : alarm_r;
                default: alarm_nxt_s = alarm_r;
            endcase
        end else begin
            alarm_nxt_s = alarm_r;
        end
        if (fsm_r == S_EXEC) begin
            case (op_r)
                SET_HI: err_s = !(opnd_r > lo_r);
                SET_LO: err_s = !(opnd_r < hi_r);
                ENABLE: begin
                    if (!enabled_s) begin
                        alarm_nxt_s = ST_NORMAL;
                        cmd_clr_s   = 1'b1;
                    end else begin
                        cmd_clr_s   = 1'b0;
                    end
                end
                DISABLE: begin
                    alarm_nxt_s = ST_DISABLED;
                    cmd_clr_s   = 1'b1;
                end
                CLEAR: begin
                    if (enabled_s) begin
                        alarm_nxt_s = ST_NORMAL;
                        cmd_clr_s   = 1'b1;
                    end else begin
                        cmd_clr_s   = 1'b0;
                    end
                end
                default: err_s = 1'b0;
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Any alarm state change restarts both debounce counters
    assign clr_s = cmd_clr_s || (alarm_nxt_s != alarm_r);

    // Command latch and sequencer state
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r  <= S_IDLE;
            op_r   <= NOP;
            opnd_r <= '0;
        end else begin
            fsm_r <= fsm_nxt_s;
            if (accept_s) begin
                op_r   <= bus.op;
                opnd_r <= bus.opnd;
            end else begin
                op_r   <= op_r;
                opnd_r <= opnd_r;
            end
        end
    end

    // Configuration registers, written at the end of EXEC when not rejected
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r   <= TMON_HI_RST;
            lo_r   <= TMON_LO_RST;
            hyst_r <= TMON_HYST_RST;
        end else if ((fsm_r == S_EXEC) && !err_s) begin
            case (op_r)
                SET_HI:   hi_r   <= opnd_r;
                SET_LO:   lo_r   <= opnd_r;
                SET_HYST: hyst_r <= opnd_r;
                default: begin
                    hi_r   <= hi_r;
                    lo_r   <= lo_r;
                    hyst_r <= hyst_r;
                end
            endcase
        end else begin
            hi_r   <= hi_r;
            lo_r   <= lo_r;
            hyst_r <= hyst_r;
        end
    end

    // Alarm state and registered bus/alarm outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_r      <= ST_DISABLED;
            status_r     <= ST_DISABLED;
            valid_r      <= 1'b0;
            ready_r      <= 1'b0;
            alarm_hot_r  <= 1'b0;
            alarm_cold_r <= 1'b0;
        end else begin
            alarm_r      <= alarm_nxt_s;
            // status tracks the live alarm state except in the response cycle
            status_r     <= ((fsm_r == S_EXEC) && err_s) ? ST_ERR : alarm_nxt_s;
            valid_r      <= (fsm_r == S_EXEC);
            ready_r      <= (fsm_nxt_s == S_IDLE);
            alarm_hot_r  <= (alarm_nxt_s == ST_HOT);
            alarm_cold_r <= (alarm_nxt_s == ST_COLD);
        end
    end

    assign bus.status = status_r;
    assign bus.valid  = valid_r;
    assign bus.ready  = ready_r;
    assign alarm_hot  = alarm_hot_r;
    assign alarm_cold = alarm_cold_r;

endmodule

// File: tb/tb_tmon_alarm_slave.sv
// ---------------------------------------------------------------------------
// tb_tmon_alarm_slave
// Directed self-checking bench for tmon_alarm_slave with hand-computed
// expectations (hi=200, lo=10, hyst=2, DEBOUNCE=4 after reset).
// ---------------------------------------------------------------------------
module tb_tmon_alarm_slave;
    import tmon_alarm_slave_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] temp_in;
    logic       temp_vld;
    logic       alarm_hot, alarm_cold;
    int         n_chk  = 0;
    int         n_pass = 0;

    tmon_bus #(.DTYPE(logic [7:0])) bus_if ();

    tmon_alarm_slave #(.DTYPE(logic [7:0]), .DEBOUNCE(4)) dut (
        .clk(clk), .reset(reset), .bus(bus_if),
        .temp_in(temp_in), .temp_vld(temp_vld),
        .alarm_hot(alarm_hot), .alarm_cold(alarm_cold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [7:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            temp_in  = t;
            temp_vld = 1'b1;
            tick();
            temp_vld = 1'b0;
        end
    endtask

    // Issue one command; optionally present a sample in the EXEC cycle
    task automatic do_cmd(input string tag, input tmon_op_e op, input logic [7:0] opnd,
                          input tmon_status_e exp, input logic xv, input logic [7:0] xt);
        int waitc;
        waitc = 0;
        while (!bus_if.ready && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!bus_if.ready) begin
            chk({tag, "_ready_timeout"}, 32'(bus_if.ready), 32'd1);
        end else begin
            bus_if.op   = op;
            bus_if.opnd = opnd;
            tick();
            bus_if.op   = NOP;
            bus_if.opnd = 8'd0;
            temp_in     = xt;
            temp_vld    = xv;
            chk({tag, "_exec_rdy_vld"}, 32'({bus_if.ready, bus_if.valid}), 32'd0);
            tick();
            temp_vld = 1'b0;
            chk({tag, "_valid"}, 32'(bus_if.valid), 32'd1);
            chk({tag, "_status"}, 32'(bus_if.status), 32'(exp));
            tick();
            chk({tag, "_done_rdy_vld"}, 32'({bus_if.ready, bus_if.valid}), 32'd2);
        end
    endtask

    initial begin
        int vseen;
        reset       = 1'b1;
        temp_in     = 8'd0;
        temp_vld    = 1'b0;
        bus_if.op   = NOP;
        bus_if.opnd = 8'd0;
        tick();
        tick();
        chk("rst_ready", 32'(bus_if.ready), 32'd0);
        chk("rst_valid", 32'(bus_if.valid), 32'd0);
        chk("rst_status", 32'(bus_if.status), 32'(ST_DISABLED));
        chk("rst_alarms", 32'({alarm_hot, alarm_cold}), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus_if.ready), 32'd1);

        // Disabled: samples ignored
        do_cmd("query", QUERY, 8'd0, ST_DISABLED, 1'b0, 8'd0);
        sample(8'd250, 4);
        chk("dis_no_hot", 32'(alarm_hot), 32'd0);

        // Debounce to HOT
        do_cmd("enable", ENABLE, 8'd0, ST_NORMAL, 1'b0, 8'd0);
        sample(8'd201, 3);
        chk("hot_after3", 32'(alarm_hot), 32'd0);
        sample(8'd201, 1);
        chk("hot_after4", 32'(alarm_hot), 32'd1);
        chk("hot_status", 32'(bus_if.status), 32'(ST_HOT));

        // Hysteresis exit at hi-hyst = 198
        sample(8'd198, 1);
        chk("hot_keep_198", 32'(alarm_hot), 32'd1);
        sample(8'd197, 1);
        chk("hot_exit_197", 32'(alarm_hot), 32'd0);
        chk("normal_status", 32'(bus_if.status), 32'(ST_NORMAL));

        // Broken run: 201,201,199 restarts the count
        sample(8'd201, 2);
        sample(8'd199, 1);
        sample(8'd201, 3);
        chk("broken_run_6", 32'(alarm_hot), 32'd0);
        sample(8'd201, 1);
        chk("broken_run_7", 32'(alarm_hot), 32'd1);

        // Saturated lower bound (0): nothing can exit HOT
        do_cmd("hyst255", SET_HYST, 8'd255, ST_HOT, 1'b0, 8'd0);
        sample(8'd0, 1);
        chk("hyst_sat_keep", 32'(alarm_hot), 32'd1);
        do_cmd("hyst2", SET_HYST, 8'd2, ST_HOT, 1'b0, 8'd0);

        // DISABLE beats a concurrent exiting sample
        do_cmd("disable", DISABLE, 8'd0, ST_DISABLED, 1'b1, 8'd100);
        chk("disable_hot_clr", 32'(alarm_hot), 32'd0);

        // Cold side, exit above lo+hyst = 12
        do_cmd("enable2", ENABLE, 8'd0, ST_NORMAL, 1'b0, 8'd0);
        sample(8'd9, 4);
        chk("cold_after4", 32'(alarm_cold), 32'd1);
        sample(8'd12, 1);
        chk("cold_keep_12", 32'(alarm_cold), 32'd1);
        sample(8'd13, 1);
        chk("cold_exit_13", 32'(alarm_cold), 32'd0);

        // Rejected threshold writes
        do_cmd("setlo250", SET_LO, 8'd250, ST_ERR, 1'b0, 8'd0);
        chk("err_status_back", 32'(bus_if.status), 32'(ST_NORMAL));
        sample(8'd100, 4);
        chk("lo_unchanged", 32'(alarm_cold), 32'd0);
        do_cmd("sethi5", SET_HI, 8'd5, ST_ERR, 1'b0, 8'd0);
        do_cmd("sethi100", SET_HI, 8'd100, ST_NORMAL, 1'b0, 8'd0);
        sample(8'd150, 4);
        chk("hi100_hot", 32'(alarm_hot), 32'd1);

        // Reset during EXEC aborts the command
        bus_if.op   = SET_HI;
        bus_if.opnd = 8'd150;
        tick();
        bus_if.op   = NOP;
        bus_if.opnd = 8'd0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        vseen = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_if.valid) vseen++;
            tick();
        end
        chk("abort_no_valid", 32'(vseen), 32'd0);
        chk("abort_status", 32'(bus_if.status), 32'(ST_DISABLED));
        chk("abort_alarm", 32'(alarm_hot), 32'd0);
        do_cmd("enable3", ENABLE, 8'd0, ST_NORMAL, 1'b0, 8'd0);
        sample(8'd199, 4);
        chk("hi_rst_199", 32'(alarm_hot), 32'd0);
        sample(8'd201, 4);
        chk("hi_rst_201", 32'(alarm_hot), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
